// File: rtl/cache_mem_sequencer.sv
// cache_mem_sequencer
// Turns the cache's combinational miss / dirty-eviction flags into memory
// traffic on a single-port, variable-latency memory. An eviction is written
// back first, then the missed word is read and handed to the cache as a
// one-cycle fill pulse. The pipeline is stalled for the whole sequence.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   miss_req, fill_addr             cache read request and its address
//   evict_req, evict_addr/_data     cache dirty write-back request
//   fill_valid, fill_data           one-cycle fill pulse and returned word
//   stall                           freeze pipeline and cache inputs
//   mem_req/_we/_addr/_wdata        registered memory request, held until mem_ready
//   mem_ready, mem_rdata            memory completion and read data
//   err_timeout                     sticky memory-timeout flag
//   miss_count, wb_count            saturating refill / write-back counters
module cache_mem_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic                  evict_req,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  input  logic [DATA_WIDTH-1:0] evict_data,
  output logic                  fill_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err_timeout,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  // The wait counter only has to reach TIMEOUT_CYCLES-1: the cycle in which
  // it holds that value is the last permitted wait cycle.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic                  pending_miss;
  logic [CW-1:0]         wait_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Combinational so the request cycle itself already freezes the pipeline.
  assign stall = (state != S_IDLE) | miss_req | evict_req;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fill_addr_q  <= '0;
      pending_miss <= 1'b0;
      wait_cnt     <= '0;
      fill_valid   <= 1'b0;
      fill_data    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err_timeout  <= 1'b0;
      miss_count   <= '0;
      wb_count     <= '0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (evict_req || miss_req) begin
            fill_addr_q  <= fill_addr;
            pending_miss <= miss_req;
            wait_cnt     <= '0;
            mem_req      <= 1'b1;
            if (miss_req) miss_count <= sat_inc(miss_count);
            if (evict_req) begin
              state     <= S_WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= evict_addr;
              mem_wdata <= evict_data;
              wb_count  <= sat_inc(wb_count);
            end else begin
              state    <= S_REFILL;
              mem_we   <= 1'b0;
              mem_addr <= fill_addr;
            end
          end
        end

        S_WRITEBACK: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (pending_miss) begin
              // Chain straight into the read; mem_req stays high.
              state    <= S_REFILL;
              mem_addr <= fill_addr_q;
              wait_cnt <= '0;
            end else begin
              state   <= S_DONE;
              mem_req <= 1'b0;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort drops the pending refill; no fill pulse for a write abort.
            state        <= S_DONE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            err_timeout  <= 1'b1;
            pending_miss <= 1'b0;
            fill_data    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_REFILL: begin
          // mem_ready is tested first so a completion on the timeout cycle wins.
          if (mem_ready) begin
            state      <= S_DONE;
            mem_req    <= 1'b0;
            fill_data  <= mem_rdata;
            fill_valid <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= S_DONE;
            mem_req      <= 1'b0;
            err_timeout  <= 1'b1;
            pending_miss <= 1'b0;
            fill_data    <= '0;
            fill_valid   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_sequencer.sv
// Directed bench for cache_mem_sequencer, built with TIMEOUT_CYCLES=4 so the
// timeout path is reachable. Inputs change and outputs are sampled on the
// falling edge; the DUT updates on the rising edge.
module tb_cache_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req, evict_req, mem_ready;
  logic [31:0] fill_addr, evict_addr, evict_data, mem_rdata;
  logic        fill_valid, stall, mem_req, mem_we, err_timeout;
  logic [31:0] fill_data, mem_addr, mem_wdata, miss_count, wb_count;

  int total = 0;
  int bad   = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  cache_mem_sequencer #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_req   (miss_req),
    .fill_addr  (fill_addr),
    .evict_req  (evict_req),
    .evict_addr (evict_addr),
    .evict_data (evict_data),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .err_timeout(err_timeout),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the next falling edge; tally stall cycles.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (stall) stall_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    miss_req = 1'b0; evict_req = 1'b0; mem_ready = 1'b0;
    fill_addr = '0; evict_addr = '0; evict_data = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_fill_valid", fill_valid, 0);
    check("rst_fill_data", fill_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_err", err_timeout, 0);

    // Idle: ten quiet cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_stall", stall, 0);
      check("idle_mem_req", mem_req, 0);
    end
    check("idle_miss_count", miss_count, 0);
    check("idle_wb_count", wb_count, 0);

    // Clean miss, memory ready on the third request cycle.
    miss_req = 1'b1; fill_addr = 32'h0000_1040;
    #1;
    check("miss_req_cycle_stall", stall, 1);
    stall_cnt = 1;
    tick();
    miss_req = 1'b0; fill_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("miss_mem_req", mem_req, 1);
      check("miss_mem_we", mem_we, 0);
      check("miss_mem_addr", mem_addr, 32'h0000_1040);
      check("miss_no_fill_yet", fill_valid, 0);
      if (i == 2) begin mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("miss_fill_valid", fill_valid, 1);
    check("miss_fill_data", fill_data, 32'hDEAD_BEEF);
    check("miss_done_mem_req", mem_req, 0);
    check("miss_count_1", miss_count, 1);
    tick();
    check("miss_fill_pulse_end", fill_valid, 0);
    check("miss_fill_data_hold", fill_data, 32'hDEAD_BEEF);
    check("miss_stall_cycles", stall_cnt, 5);

    // Eviction + miss together: write 0x2000 then read 0x4000, 2 cycles each.
    evict_req = 1'b1; miss_req = 1'b1;
    evict_addr = 32'h2000; evict_data = 32'h1234_5678; fill_addr = 32'h4000;
    #1;
    check("ev_req_cycle_stall", stall, 1);
    tick();
    evict_req = 1'b0; miss_req = 1'b0;
    evict_addr = 32'h0; evict_data = 32'h0; fill_addr = 32'h0;
    check("ev_wb_mem_req", mem_req, 1);
    check("ev_wb_mem_we", mem_we, 1);
    check("ev_wb_mem_addr", mem_addr, 32'h2000);
    check("ev_wb_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    check("ev_wb_still_writing", mem_we, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("ev_rf_mem_req", mem_req, 1);
    check("ev_rf_mem_we", mem_we, 0);
    check("ev_rf_mem_addr", mem_addr, 32'h4000);
    check("ev_rf_no_fill", fill_valid, 0);
    check("ev_wb_count", wb_count, 1);
    check("ev_miss_count", miss_count, 2);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("ev_fill_valid", fill_valid, 1);
    check("ev_fill_data", fill_data, 32'hCAFE_F00D);
    tick();
    check("ev_idle_stall", stall, 0);
    check("ev_idle_fill_valid", fill_valid, 0);

    // Eviction only: single write, DONE without a fill pulse.
    evict_req = 1'b1; evict_addr = 32'h3000; evict_data = 32'hAAAA_5555;
    tick();
    evict_req = 1'b0; evict_addr = 32'h0; evict_data = 32'h0;
    check("wbo_mem_we", mem_we, 1);
    check("wbo_mem_addr", mem_addr, 32'h3000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wbo_done_fill_valid", fill_valid, 0);
    check("wbo_done_mem_req", mem_req, 0);
    check("wbo_done_stall", stall, 1);
    check("wbo_fill_data_hold", fill_data, 32'hCAFE_F00D);
    check("wbo_wb_count", wb_count, 2);
    check("wbo_miss_count", miss_count, 2);
    tick();
    check("wbo_idle_stall", stall, 0);

    // Ready on the final permitted wait cycle wins over the timeout.
    miss_req = 1'b1; fill_addr = 32'h6000;
    tick();
    miss_req = 1'b0; fill_addr = 32'h0;
    repeat (3) tick();
    check("edge_still_req", mem_req, 1);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("edge_fill_valid", fill_valid, 1);
    check("edge_fill_data", fill_data, 32'h0000_0077);
    check("edge_no_err", err_timeout, 0);
    tick();

    // Timeout during refill: four wait cycles without mem_ready.
    miss_req = 1'b1; fill_addr = 32'h5000;
    tick();
    miss_req = 1'b0; fill_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("to_mem_req", mem_req, 1);
      check("to_err_low", err_timeout, 0);
      tick();
    end
    check("to_err", err_timeout, 1);
    check("to_fill_valid", fill_valid, 1);
    check("to_fill_data", fill_data, 0);
    check("to_mem_req_low", mem_req, 0);
    check("to_miss_count", miss_count, 4);
    tick();
    check("to_err_sticky", err_timeout, 1);
    check("to_idle_stall", stall, 0);
    check("to_idle_fill_valid", fill_valid, 0);

    // Asynchronous reset two cycles into a refill wait.
    miss_req = 1'b1; fill_addr = 32'h7000;
    tick();
    miss_req = 1'b0; fill_addr = 32'h0;
    tick();
    check("ar_pre_mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_mem_req", mem_req, 0);
    check("ar_stall", stall, 0);
    check("ar_miss_count", miss_count, 0);
    check("ar_wb_count", wb_count, 0);
    check("ar_err", err_timeout, 0);
    check("ar_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_idle_stall", stall, 0);
    check("ar_idle_mem_req", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_mem_sequencer.md
Name: cache_mem_sequencer

Overview:
- Sequences main-memory traffic for the two-way write-back data cache.
- The cache flags misses and dirty evictions combinationally. This block serialises each one into a write-back followed by a refill on a single-port, variable-latency memory.
- It stalls the pipeline until the fill word is returned to the cache.
- It sits between the cache's RAM-side outputs and the main memory port, and also drives the pipeline stall line.

Parameters:
- DATA_WIDTH, 32, width of cache word and memory data.
- ADDR_WIDTH, 32, memory byte-address width.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ready before aborting (must be ≥1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  cache needs a word from memory (cache re_from_ram)
- fill_addr  in  ADDR_WIDTH  address of missed word
- evict_req  in  1  cache is evicting a dirty word (cache we_to_ram)
- evict_addr  in  ADDR_WIDTH  address of evicted word
- evict_data  in  DATA_WIDTH  evicted word
- fill_valid  out  1  one-cycle pulse; fill_data is valid for the cache to write
- fill_data  out  DATA_WIDTH  word returned from memory
- stall  out  1  freeze pipeline and cache inputs
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory completes the current access this cycle; mem_rdata valid on a read
- mem_rdata  in  DATA_WIDTH  memory read data
- err_timeout  out  1  sticky; set on any memory timeout
- miss_count  out  32  saturating count of accepted refills
- wb_count  out  32  saturating count of accepted write-backs

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registered outputs, latched addr/data, wait counter and stat counters = 0; err_timeout=0. Reset mid-access drops the access immediately; mem_req falls asynchronously.
- States: IDLE, WRITEBACK, REFILL, DONE.
- stall = (state!=IDLE) | miss_req | evict_req. This is combinational, so the request cycle itself stalls.
- IDLE:
  - Latch evict_addr/evict_data/fill_addr and pending_miss=miss_req when any request is present.
  - evict_req=1 → WRITEBACK, wb_count+1.
  - Else miss_req=1 → REFILL, miss_count+1.
  - Neither → stay.
  - If both requests are present, miss_count also +1 on entry; the write-back always precedes the refill.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched evict values.
  - On mem_ready: pending_miss → REFILL, else → DONE with fill_valid=0.
- REFILL: mem_req=1, mem_we=0, mem_addr = latched fill_addr.
  - On mem_ready: register mem_rdata into fill_data → DONE.
- DONE: fill_valid=1 for exactly one cycle only if a refill completed; stall stays high → IDLE. The cache then re-accesses and hits.
- mem_req, mem_we, mem_addr and mem_wdata are registered outputs, stable for the whole access. mem_req is 0 in IDLE and DONE.
- Outputs in IDLE: mem_addr/mem_wdata hold their last value; fill_data holds its last value.
- Latency:
  - Refill only: 1 (IDLE) + N_ready + 1 (DONE) cycles of stall.
  - Write-back + refill: adds the write-back wait.
- Wait counter:
  - Resets to 0 on entering WRITEBACK or REFILL; increments each cycle without mem_ready.
  - Reaching TIMEOUT_CYCLES sets err_timeout, clears pending_miss, forces fill_data=0 and goes to DONE. fill_valid pulses only if the abort happened in REFILL.
  - mem_ready arriving in the same cycle as the timeout wins; no error.
- Requests arriving outside IDLE are ignored. The pipeline holds them because stall is high; they are re-sampled in IDLE.
- Counters saturate at 32'hFFFF_FFFF.

Test Plan:
- Reset then idle: no requests for 10 cycles → stall=0, mem_req=0, all counters 0.
- Clean miss: miss_req with fill_addr=0x0000_1040; memory returns 0xDEAD_BEEF after 3 cycles.
  - Expect mem_req=1, mem_we=0, mem_addr=0x1040 for 3 cycles.
  - Then fill_valid=1 with fill_data=0xDEAD_BEEF for exactly one cycle.
  - stall high for 5 cycles; miss_count=1.
- Dirty eviction plus miss in the same cycle: evict_addr=0x2000, evict_data=0x1234_5678, fill_addr=0x4000; ready after 2 cycles each.
  - Expect a write to 0x2000 first, then a read of 0x4000; one fill_valid.
  - wb_count=1, miss_count=1.
- Eviction only: evict_req without miss_req → single write, DONE with fill_valid=0, back to IDLE.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 during a refill → after 4 wait cycles err_timeout=1 (sticky), fill_valid=1 with fill_data=0, then IDLE.
- Async reset mid-REFILL: assert rst_n=0 two cycles into the wait → mem_req and stall drop within the same cycle, state=IDLE, counters=0.
